// File: rtl/cross_product_arbiter.sv
// cross_product_arbiter
//   Round-robin arbiter (with bounded lock) in front of a 3-stage pipeline that
//   computes the sign of the 2-D cross product Ax*By - Bx*Ay for the granted
//   requester.
//
// Ports
//   clk        in   clock, all state on rising edge
//   reset      in   synchronous, active-low reset
//   req        in   per-requester request
//   lock       in   per-requester request to keep priority next cycle
//   op_bus     in   packed operands, requester i at [44i+43:44i] = {Ax,Ay,Bx,By}
//   gnt        out  one-hot grant (combinational)
//   rsp_valid  out  one-cycle result strobe, 3 edges after the grant edge
//   rsp_id     out  requester owning the current result
//   rsp_pos    out  Ax*By > Bx*Ay
//   rsp_zero   out  Ax*By == Bx*Ay (only with CROSS_PRODUCT_ZERO_FLAG_EN)
//   busy       out  any pipeline stage holds a valid operation
//
// Configuration
//   CROSS_PRODUCT_ZERO_FLAG_EN  adds the rsp_zero port and its equality compare.

module cross_product_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        lock,
    input  logic [44*NREQ-1:0]     op_bus,
    output logic [NREQ-1:0]        gnt,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_id,
    output logic                   rsp_pos,
`ifdef CROSS_PRODUCT_ZERO_FLAG_EN
    output logic                   rsp_zero,
`endif
    output logic                   busy
);

    localparam int unsigned IdW  = 2;
    localparam int unsigned OpW  = 44;
    localparam int unsigned EW   = 11;
    localparam int unsigned PW   = 2 * EW;
    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

    // Arbitration state
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] run;
    logic [IdW-1:0]  cand;
    logic [IdW-1:0]  gnt_idx;
    logic            gnt_any;
    logic [OpW-1:0]  op_sel;

    // Pipeline state
    logic                  s1_v, s2_v;
    logic [IdW-1:0]        s1_id, s2_id;
    logic signed [EW-1:0]  s1_ax, s1_ay, s1_bx, s1_by;
    logic signed [PW-1:0]  s2_ab, s2_ba;

    // Search upward from ptr, wrapping naturally in the 2-bit index.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = ptr_q + IdW'(k);
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (!reset) begin
            gnt_any = 1'b0;
        end
    end

    assign gnt    = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    assign op_sel = op_bus[int'(gnt_idx) * OpW +: OpW];

    // A nonzero count always belongs to the requester parked at ptr, so a grant
    // to ptr_q with cnt_q != 0 continues the same locked run.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = '0;
        run   = '0;
        if (gnt_any) begin
            if (lock[gnt_idx]) begin
                run = (gnt_idx == ptr_q && cnt_q != '0) ? cnt_q + CntW'(1) : CntW'(1);
                if (run == CntW'(LOCK_MAX)) begin
                    ptr_d = gnt_idx + IdW'(1);
                    cnt_d = '0;
                end else begin
                    ptr_d = gnt_idx;
                    cnt_d = run;
                end
            end else begin
                ptr_d = gnt_idx + IdW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Stage 1: capture the granted requester's operands.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v  <= 1'b0;
            s1_id <= '0;
        end else begin
            s1_v <= gnt_any;
            if (gnt_any) begin
                s1_id <= gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_any) begin
            s1_ax <= op_sel[43:33];
            s1_ay <= op_sel[32:22];
            s1_bx <= op_sel[21:11];
            s1_by <= op_sel[10:0];
        end
    end

    // Stage 2: the two products; 22 bits hold any 11x11 signed product exactly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_v  <= 1'b0;
            s2_id <= '0;
        end else begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_id <= s1_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_v) begin
            s2_ab <= PW'(s1_ax) * PW'(s1_by);
            s2_ba <= PW'(s1_bx) * PW'(s1_ay);
        end
    end

    // Stage 3: signed compare; result fields hold between strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_pos   <= 1'b0;
`ifdef CROSS_PRODUCT_ZERO_FLAG_EN
            rsp_zero  <= 1'b0;
`endif
        end else begin
            rsp_valid <= s2_v;
            if (s2_v) begin
                rsp_id   <= s2_id;
                rsp_pos  <= s2_ab > s2_ba;
`ifdef CROSS_PRODUCT_ZERO_FLAG_EN
                rsp_zero <= s2_ab == s2_ba;
`endif
            end
        end
    end

    assign busy = s1_v | s2_v | rsp_valid;

endmodule

// File: tb/tb_cross_product_arbiter.sv
// Scoreboard bench for cross_product_arbiter: a driver applies stimulus on the
// falling edge, checks the combinational grant against a reference model and
// queues the expected result; a monitor pops and compares on every strobe.

module tb_cross_product_arbiter;

    localparam int LOCK_MAX = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req, lock, gnt;
    logic [175:0] op_bus;
    logic         rsp_valid, rsp_pos, busy;
    logic [1:0]   rsp_id;
`ifdef CROSS_PRODUCT_ZERO_FLAG_EN
    logic         rsp_zero;
`endif

    always #5 clk = ~clk;

    cross_product_arbiter #(.NREQ(4), .LOCK_MAX(LOCK_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .op_bus    (op_bus),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_pos   (rsp_pos),
`ifdef CROSS_PRODUCT_ZERO_FLAG_EN
        .rsp_zero  (rsp_zero),
`endif
        .busy      (busy)
    );

    typedef struct {
        int id;
        bit pos;
        bit zero;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state
    int m_ptr = 0, m_run = 0, m_owner = 0;
    int last_id = 0;
    bit last_pos = 0, last_zero = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [43:0] mk(input int ax, input int ay, input int bx, input int by);
        logic [10:0] a, b, c, d;
        a = 11'(ax); b = 11'(ay); c = 11'(bx); d = 11'(by);
        return {a, b, c, d};
    endfunction

    function automatic int sx(input logic [10:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [175:0] rnd_ops();
        logic [191:0] t;
        for (int j = 0; j < 6; j++) t[j*32 +: 32] = $urandom;
        return t[175:0];
    endfunction

    // One cycle of stimulus plus the reference model's view of that cycle.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                        input logic [175:0] ops);
        int g;
        int run;
        logic [43:0] s;
        exp_t e;
        @(negedge clk);
        #2;
        reset = r; req = rq; lock = lk; op_bus = ops;
        #1;
        if (!r) begin
            check("gnt_in_reset", 32'(gnt), 32'd0);
            sb.delete();
            m_ptr = 0; m_run = 0; m_owner = 0;
            last_id = 0; last_pos = 0; last_zero = 0;
        end else begin
            g = -1;
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && rq[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
            check("gnt", 32'(gnt), (g < 0) ? 32'd0 : (32'd1 << g));
            if (g >= 0) begin
                s = ops[g*44 +: 44];
                e.id   = g;
                e.pos  = sx(s[43:33]) * sx(s[10:0]) > sx(s[21:11]) * sx(s[32:22]);
                e.zero = sx(s[43:33]) * sx(s[10:0]) == sx(s[21:11]) * sx(s[32:22]);
                e.due  = cyc + 3;
                sb.push_back(e);
                if (lk[g]) begin
                    run = (m_run > 0 && m_owner == g) ? m_run + 1 : 1;
                    if (run == LOCK_MAX) begin
                        m_ptr = (g + 1) % 4;
                        m_run = 0;
                    end else begin
                        m_ptr = g;
                        m_run = run;
                        m_owner = g;
                    end
                end else begin
                    m_ptr = (g + 1) % 4;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    // Monitor: runs before the driver in every falling-edge slot.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            check("busy", 32'(busy), 32'(sb.size() > 0));
            if (rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_latency", 32'(cyc), 32'(e.due));
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_pos", 32'(rsp_pos), 32'(e.pos));
`ifdef CROSS_PRODUCT_ZERO_FLAG_EN
                    check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
`endif
                    last_id = e.id; last_pos = e.pos; last_zero = e.zero;
                end
            end else begin
                check("rsp_valid", 32'(rsp_valid), 32'd0);
                check("rsp_id_hold", 32'(rsp_id), 32'(last_id));
                check("rsp_pos_hold", 32'(rsp_pos), 32'(last_pos));
`ifdef CROSS_PRODUCT_ZERO_FLAG_EN
                check("rsp_zero_hold", 32'(rsp_zero), 32'(last_zero));
`endif
            end
        end
    end

    initial begin
        logic [175:0] ob;
        reset = 1'b0; req = '0; lock = '0; op_bus = '0;
        repeat (2) step(1'b0, 4'b0000, 4'b0000, '0);

        // Single operation: 3*4 > 1*1
        ob = '0; ob[43:0] = mk(3, 1, 1, 4);
        step(1'b1, 4'b0001, 4'b0000, ob);
        repeat (4) step(1'b1, 4'b0000, 4'b0000, rnd_ops());

        // Extreme signed operands, then the swapped pair
        ob = '0; ob[43:0] = mk(-1024, 1023, 1023, -1024);
        step(1'b1, 4'b0001, 4'b0000, ob);
        ob = '0; ob[43:0] = mk(1023, -1024, -1024, 1023);
        step(1'b1, 4'b0001, 4'b0000, ob);

        // Collinear and nearly collinear
        ob = '0; ob[43:0] = mk(2, 4, 1, 2);
        step(1'b1, 4'b0001, 4'b0000, ob);
        ob = '0; ob[43:0] = mk(2, 4, 1, 3);
        step(1'b1, 4'b0001, 4'b0000, ob);
        repeat (4) step(1'b1, 4'b0000, 4'b0000, rnd_ops());

        // Plain round-robin with all requesters active
        repeat (8) step(1'b1, 4'b1111, 4'b0000, rnd_ops());

        // Lock cap on requester 2
        repeat (14) step(1'b1, 4'b1111, 4'b0100, rnd_ops());
        repeat (4) step(1'b1, 4'b0000, 4'b0000, rnd_ops());

        // Reset with two operations in flight, then ptr restarts at 0
        repeat (2) step(1'b1, 4'b0011, 4'b0000, rnd_ops());
        step(1'b0, 4'b0011, 4'b0000, rnd_ops());
        repeat (4) step(1'b1, 4'b0000, 4'b0000, rnd_ops());
        step(1'b1, 4'b0010, 4'b0000, rnd_ops());
        repeat (4) step(1'b1, 4'b0000, 4'b0000, rnd_ops());

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            logic [3:0] rq, lk;
            rq = 4'($urandom);
            lk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if (i % 100 < 50) lk = rq;
            step(($urandom_range(0, 60) != 0), rq, lk, rnd_ops());
        end

        repeat (6) step(1'b1, 4'b0000, 4'b0000, rnd_ops());
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
